// File: rtl/s2p_frame_ctrl_pkg.sv
// Shared definitions for the serial-to-parallel frame receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the default abort timeout and a helper
// that expands the 4-bit length field (0 means 16 bits).
package s2p_frame_ctrl_pkg;

  localparam int DEFAULT_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  function automatic logic [4:0] decode_len(input logic [3:0] l);
    return (l == 4'd0) ? 5'd16 : {1'b0, l};
  endfunction

endpackage

// File: rtl/s2p_frame_ctrl_shift.sv
// rx_shift16: 16-bit MSB-first shift register with a 5-bit bit counter.
// Latency: word/cnt update on the clk edge after clear or shift.
// Backpressure: none; the caller sequences clear/shift.
//
// Ports: clk, reset (async active-high), clear (zero word and count),
//        shift (shift ser_bit into bit 0), ser_bit, word[15:0], cnt[4:0].
// Once 16 bits are in, further shifts are ignored so the word never wraps.
module rx_shift16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic        ser_bit,
  output logic [15:0] word,
  output logic [4:0]  cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word <= '0;
      cnt  <= '0;
    end else if (clear) begin
      word <= '0;
      cnt  <= '0;
    end else if (shift && (cnt != 5'd16)) begin
      word <= {word[14:0], ser_bit};
      cnt  <= cnt + 5'd1;
    end
  end

endmodule

// File: rtl/s2p_frame_ctrl.sv
// s2p_frame_ctrl: receives framed serial words (start, 1-16 data bits,
//   optional odd parity, stop) clocked by an asynchronous ser_clk.
// Latency: SYNC_STAGES+1 clk cycles from the ser_clk fall of the stop bit
//   to data_valid; data_valid drops the cycle after data_valid&data_ready.
// Backpressure: a held word waits for data_ready; start bits arriving
//   meanwhile are dropped and flagged with an overrun pulse.
//
// Ports: clk, reset (async active-high), ser_clk, ser_data, len (0=16),
//        parity_en, data_out[15:0], data_valid, data_ready, busy,
//        frame_err, parity_err, overrun (error outputs are 1-cycle pulses).
module s2p_frame_ctrl
  import s2p_frame_ctrl_pkg::*;
#(
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ser_clk,
  input  logic        ser_data,
  input  logic [3:0]  len,
  input  logic        parity_en,
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        busy,
  output logic        frame_err,
  output logic        parity_err,
  output logic        overrun
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  // Synchronizers reset to 1 so an idle-high line produces no false edge.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ser_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ser_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  logic fall;
  logic sample;
  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign sample = dat_sync[SYNC_STAGES-1];

  state_t        state;
  logic [4:0]    len_q;
  logic          par_en_q;
  logic          par_bad;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   word;
  logic [4:0]    bit_cnt;
  logic          sh_clear;
  logic          sh_shift;

  assign sh_clear = (state == ST_IDLE) && fall && !sample;
  assign sh_shift = (state == ST_DATA) && fall;

  rx_shift16 u_shift (
    .clk     (clk),
    .reset   (reset),
    .clear   (sh_clear),
    .shift   (sh_shift),
    .ser_bit (sample),
    .word    (word),
    .cnt     (bit_cnt)
  );

  assign data_valid = (state == ST_HOLD);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_bad    <= 1'b0;
      tmo_cnt    <= '0;
      data_out   <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (fall && !sample) begin
            len_q    <= decode_len(len);
            par_en_q <= parity_en;
            par_bad  <= 1'b0;
            state    <= ST_DATA;
          end
        end
        ST_DATA, ST_PARITY, ST_STOP: begin
          // An edge in the same cycle as the timeout wins.
          if (fall) begin
            tmo_cnt <= '0;
            if (state == ST_DATA) begin
              // bit_cnt is the pre-shift count in the edge cycle.
              if (bit_cnt + 5'd1 == len_q)
                state <= par_en_q ? ST_PARITY : ST_STOP;
            end else if (state == ST_PARITY) begin
              // Upper word bits are zero, so the full reduction is the data weight.
              if (!(^{word, sample})) begin
                parity_err <= 1'b1;
                par_bad    <= 1'b1;
              end
              state <= ST_STOP;
            end else begin
              if (!sample) begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
              end else if (par_bad) begin
                state <= ST_IDLE;
              end else begin
                data_out <= word;
                state    <= ST_HOLD;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            frame_err <= 1'b1;
            tmo_cnt   <= '0;
            state     <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (fall && !sample)
            overrun <= 1'b1;
          if (data_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Directed bench for s2p_frame_ctrl: good frame, parity error, stop error,
// timeout abort, overrun while holding, and async reset mid-frame.
module tb_s2p_frame_ctrl;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ser_clk = 1'b1;
  logic        ser_data = 1'b1;
  logic [3:0]  len = 4'd8;
  logic        parity_en = 1'b0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready = 1'b0;
  logic        busy;
  logic        frame_err;
  logic        parity_err;
  logic        overrun;

  int vec_cnt = 0;
  int err_cnt = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, dv_rise = 0;
  logic dv_prev = 1'b0;

  always #5 clk = ~clk;

  s2p_frame_ctrl #(.TIMEOUT(TMO), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .ser_clk    (ser_clk),
    .ser_data   (ser_data),
    .len        (len),
    .parity_en  (parity_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  // Pulse/edge monitors sampled on the inactive edge.
  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overrun)    ov_cnt++;
    if (data_valid && !dv_prev) dv_rise++;
    dv_prev = data_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One serial bit: data set up with ser_clk high, then a falling edge.
  task automatic send_bit(input logic b);
    @(negedge clk);
    ser_data = b;
    ser_clk  = 1'b1;
    repeat (3) @(negedge clk);
    ser_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic idle_line();
    @(negedge clk);
    ser_clk  = 1'b1;
    ser_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  int fe0, pe0, ov0, dv0, lat;

  initial begin
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_errs", {29'd0, frame_err, parity_err, overrun}, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0xA5, len 8, odd parity bit 1, stop 1
    fe0 = fe_cnt; pe0 = pe_cnt;
    len = 4'd8; parity_en = 1'b1;
    send_bit(1'b0);
    send_bits(16'h00A5, 8);
    send_bit(1'b1);
    @(negedge clk);
    ser_data = 1'b1; ser_clk = 1'b1;
    repeat (3) @(negedge clk);
    ser_clk = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (data_valid) lat = k;
    end
    check("a5_valid_latency", 32'(lat), 32'd3);
    check("a5_data_out", 32'(data_out), 32'h00A5);
    check("a5_no_errs", 32'((fe_cnt - fe0) + (pe_cnt - pe0)), 32'd0);
    @(negedge clk);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    check("a5_accepted", 32'(data_valid), 32'h0);
    idle_line();

    // Same frame with wrong parity bit
    pe0 = pe_cnt; dv0 = dv_rise;
    send_bit(1'b0);
    send_bits(16'h00A5, 8);
    send_bit(1'b0);
    send_bit(1'b1);
    idle_line();
    check("par_err_pulse", 32'(pe_cnt - pe0), 32'd1);
    check("par_no_valid", 32'(dv_rise - dv0), 32'd0);
    check("par_busy", 32'(busy), 32'h0);

    // len 0 (16 bits), no parity, 0xBEEF, bad stop; len changed mid-frame
    fe0 = fe_cnt; dv0 = dv_rise;
    len = 4'd0; parity_en = 1'b0;
    send_bit(1'b0);
    len = 4'd5; parity_en = 1'b1;
    send_bits(16'hBEEF, 16);
    send_bit(1'b0);
    idle_line();
    check("stop_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("stop_no_valid", 32'(dv_rise - dv0), 32'd0);
    check("stop_idle", 32'(busy), 32'h0);

    // Timeout abort after 3 data bits
    fe0 = fe_cnt;
    len = 4'd8; parity_en = 1'b0;
    send_bit(1'b0);
    send_bits(16'h0005, 3);
    check("tmo_busy_mid", 32'(busy), 32'h1);
    repeat (TMO + 10) @(negedge clk);
    check("tmo_one_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("tmo_busy", 32'(busy), 32'h0);
    idle_line();

    // Overrun while holding 0x5A (4 ones -> parity bit 1)
    ov0 = ov_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    len = 4'd8; parity_en = 1'b1;
    send_bit(1'b0);
    send_bits(16'h005A, 8);
    send_bit(1'b1);
    send_bit(1'b1);
    idle_line();
    check("ov_hold_valid", 32'(data_valid), 32'h1);
    send_bit(1'b0);
    idle_line();
    check("ov_pulse", 32'(ov_cnt - ov0), 32'd1);
    check("ov_data_kept", 32'(data_out), 32'h005A);
    check("ov_still_valid", 32'(data_valid), 32'h1);
    check("ov_no_other_errs", 32'((fe_cnt - fe0) + (pe_cnt - pe0)), 32'd0);
    data_ready = 1'b1;
    @(posedge clk); #1;
    check("ov_release", 32'(data_valid), 32'h0);
    @(negedge clk);
    data_ready = 1'b0;

    // Async reset after 5 of 8 data bits of 0x3C
    fe0 = fe_cnt; pe0 = pe_cnt;
    len = 4'd8; parity_en = 1'b0;
    send_bit(1'b0);
    send_bits(16'h0007, 5);
    ser_clk = 1'b1; ser_data = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_outputs", {data_out, 13'd0, data_valid, frame_err | parity_err, overrun}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_no_err", 32'((fe_cnt - fe0) + (pe_cnt - pe0)), 32'd0);
    send_bit(1'b0);
    send_bits(16'h003C, 8);
    send_bit(1'b1);
    idle_line();
    check("post_rst_valid", 32'(data_valid), 32'h1);
    check("post_rst_data", 32'(data_out), 32'h003C);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
